sobel_window_fetch: RTL and testbench
=====================================

# sobel_window_fetch

Read-side sequencer sitting directly upstream of the AHB master in the Sobel edge-detection datapath. It walks a stored 8-bit grayscale image and issues single-byte read instructions to the master over its instruction/addr_r/data_r/busy interface. Returned pixels are assembled into 3x3 neighbourhood windows, one per interior pixel. Each window is handed to the Sobel kernel over a valid/ready handshake, reusing two columns between horizontally adjacent windows.

## Interface
- IMG_W, 16: image width in pixels, 3..255
- IMG_H, 16: image height in pixels, 3..255
- BASE_ADDR, 0: byte address of pixel (0,0); pixel (x,y) lives at BASE_ADDR + y*IMG_W + x, truncated to 8 bits
- HCLK  in  1  clock; all logic on rising edge
- HRESET  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse, begins a frame walk when idle
- instruction  out  2  to master: 2'b01 read on issue cycle, 2'b00 otherwise (2'b10 never driven)
- addr_r  out  8  to master: read byte address
- addr_w  out  8  to master: tied 0
- data_w  out  8  to master: tied 0
- data_r  in  8  from master: returned read byte
- busy  in  1  from master: transfer in progress
- win_valid  out  1  window available
- win_ready  in  1  kernel accepts window
- win_data  out  72  window, row-major, byte k at [8k+7:8k]; k=0 top-left, k=4 centre, k=8 bottom-right
- win_x  out  8  centre column of presented window
- win_y  out  8  centre row of presented window
- frame_active  out  1  high from accepted frame_start until frame_done
- frame_done  out  1  one-cycle pulse after last window accepted

## Operation
- States: IDLE, ISSUE, WAIT, PRESENT, DONE.
- IDLE: frame_start=1 -> centre (1,1), column fill count 3, ISSUE. frame_start in any other state is ignored.
- Fill order is column-major. Each column is rows cy-1, cy, cy+1. Row start fills columns cx-1, cx, cx+1 (9 reads); each later window fills only column cx+1 (3 reads).
- ISSUE: waits with instruction=00 while busy=1. On a cycle with busy=0, drives instruction=01 and addr_r for exactly that cycle, then WAIT.
- WAIT: the cycle immediately after issue is ignored. Thereafter, on the first cycle with busy=0, data_r is written into the target window slot.
  - More reads pending in the fill -> ISSUE.
  - Otherwise -> PRESENT.
- PRESENT: win_valid=1.
  - win_data, win_x and win_y are held stable until win_valid&&win_ready.
  - On acceptance, if cx < IMG_W-2: shift columns left (slots 1,2 -> 0,1; 4,5 -> 3,4; 7,8 -> 6,7), cx++, fill 1 column, ISSUE.
  - Else if cy < IMG_H-2: cx=1, cy++, fill 3 columns, ISSUE.
  - Else DONE.
- No prefetch: no read is issued while win_valid=1.
- DONE: frame_done=1 for one cycle, then IDLE.
- Address arithmetic is done at 16 bits and truncated to 8; wrap modulo 256 is legal and required.
- Per frame: (IMG_W-2)(IMG_H-2) windows and 9(IMG_H-2)+3(IMG_W-3)(IMG_H-2) reads.

## Timing
- Reset values: instruction=00, addr_r=0, addr_w=0, data_w=0, win_valid=0, win_data=0, win_x=0, win_y=0, frame_active=0, frame_done=0. State is IDLE.
- HRESET mid-frame: all outputs take reset values on the next edge. Any master response still outstanding is discarded. No window is presented until a new frame_start.
- frame_start to first issue: 1 cycle (IDLE->ISSUE edge, instruction=01 on the next cycle if busy=0).
- Per read, with a master that raises busy for one cycle: issue, wait, capture = 3 cycles.
- Last capture to win_valid: 1 cycle.
- Acceptance to next issue: 1 cycle.
- frame_active rises the cycle after frame_start and falls together with the frame_done pulse.

## Test plan
- IMG_W=4, IMG_H=4, BASE_ADDR=0, memory byte = address, win_ready=1: four windows in order (1,1),(2,1),(1,2),(2,2). Window (1,1) = {0,1,2,4,5,6,8,9,10}; window (2,2) = {5,6,7,9,10,11,13,14,15}. Exactly 24 read instructions, then one frame_done pulse.
- Same setup, win_ready held 0 for 10 cycles on window (2,1): win_data constant, no instruction=01 during the stall, sequence otherwise unchanged.
- Master holds busy=1 for 5 cycles per read: instruction=01 only ever asserted with busy=0, each exactly one cycle. Captured windows identical to the first scenario.
- BASE_ADDR=250, IMG_W=4, IMG_H=4: window (1,1) addresses {250,251,252,254,255,0,2,3,4}, confirming modulo-256 wrap.
- frame_start pulsed during window (1,2): ignored, frame completes normally with 4 windows.
- HRESET asserted while in WAIT on read 12: next cycle all outputs at reset values. A subsequent frame_start produces a full, correct 4-window frame.

Source files
------------

// File: rtl/sobel_window_fetch_if.sv
// Bundle of the AHB-master read channel and the window handshake towards the Sobel kernel.
// The fetch sequencer uses the master modport; the master/kernel side uses slave.
interface sobel_window_fetch_if;
    logic [1:0]  instruction;
    logic [7:0]  addr_r;
    logic [7:0]  addr_w;
    logic [7:0]  data_w;
    logic [7:0]  data_r;
    logic        busy;
    logic        win_valid;
    logic        win_ready;
    logic [71:0] win_data;
    logic [7:0]  win_x;
    logic [7:0]  win_y;

    modport master (
        output instruction, addr_r, addr_w, data_w,
        output win_valid, win_data, win_x, win_y,
        input  data_r, busy, win_ready
    );

    modport slave (
        input  instruction, addr_r, addr_w, data_w,
        input  win_valid, win_data, win_x, win_y,
        output data_r, busy, win_ready
    );
endinterface

// File: rtl/sobel_window_fetch.sv
// Walks a stored 8-bit image with single-byte reads and assembles 3x3 windows,
// reusing two columns between horizontally adjacent windows.
module sobel_window_fetch #(
    parameter int unsigned IMG_W     = 16,
    parameter int unsigned IMG_H     = 16,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                        HCLK,
    input  logic                        HRESET,
    input  logic                        frame_start,
    output logic                        frame_active,
    output logic                        frame_done,
    sobel_window_fetch_if.master        bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    localparam logic [7:0] LAST_CX = 8'(IMG_W - 2);
    localparam logic [7:0] LAST_CY = 8'(IMG_H - 2);

    state_t           state_q, state_d;
    logic [7:0]       cx_q, cx_d;
    logic [7:0]       cy_q, cy_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       row_q, row_d;
    logic             skip_q, skip_d;
    logic [8:0][7:0]  win_q, win_d;

    logic [15:0]      pix_x;
    logic [15:0]      pix_y;
    logic [15:0]      addr_full;
    logic [3:0]       slot;
    logic             issue;

    // Address math is 16-bit; only the low byte reaches the master, so wrap is modulo 256.
    always_comb begin
        pix_x     = 16'(cx_q) + 16'(col_q) - 16'd1;
        pix_y     = 16'(cy_q) + 16'(row_q) - 16'd1;
        addr_full = 16'(BASE_ADDR) + pix_y * 16'(IMG_W) + pix_x;
        slot      = 4'(row_q) * 4'd3 + 4'(col_q);
        issue     = (state_q == S_ISSUE) && !bus.busy;
    end

    assign bus.instruction = issue ? 2'b01 : 2'b00;
    assign bus.addr_r      = issue ? addr_full[7:0] : '0;
    assign bus.addr_w      = '0;
    assign bus.data_w      = '0;
    assign bus.win_valid   = (state_q == S_PRESENT);
    assign bus.win_data    = win_q;
    assign bus.win_x       = cx_q;
    assign bus.win_y       = cy_q;
    assign frame_active    = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_PRESENT);
    assign frame_done      = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        col_d   = col_q;
        row_d   = row_q;
        skip_d  = skip_q;
        win_d   = win_q;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    cx_d    = 8'd1;
                    cy_d    = 8'd1;
                    col_d   = 2'd0;
                    row_d   = 2'd0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!bus.busy) begin
                    skip_d  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // The cycle right after issue is blind: busy may not have risen yet.
                if (skip_q) begin
                    skip_d = 1'b0;
                end else if (!bus.busy) begin
                    win_d[slot] = bus.data_r;
                    if (row_q == 2'd2) begin
                        row_d = 2'd0;
                        if (col_q == 2'd2) begin
                            state_d = S_PRESENT;
                        end else begin
                            col_d   = col_q + 2'd1;
                            state_d = S_ISSUE;
                        end
                    end else begin
                        row_d   = row_q + 2'd1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_PRESENT: begin
                if (bus.win_ready) begin
                    if (cx_q < LAST_CX) begin
                        win_d[0] = win_q[1];
                        win_d[1] = win_q[2];
                        win_d[3] = win_q[4];
                        win_d[4] = win_q[5];
                        win_d[6] = win_q[7];
                        win_d[7] = win_q[8];
                        cx_d     = cx_q + 8'd1;
                        col_d    = 2'd2;
                        row_d    = 2'd0;
                        state_d  = S_ISSUE;
                    end else if (cy_q < LAST_CY) begin
                        cx_d    = 8'd1;
                        cy_d    = cy_q + 8'd1;
                        col_d   = 2'd0;
                        row_d   = 2'd0;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
            skip_q  <= 1'b0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            col_q   <= col_d;
            row_q   <= row_d;
            skip_q  <= skip_d;
            win_q   <= win_d;
        end
    end

endmodule

// File: tb/tb_sobel_window_fetch.sv
// Scoreboard bench: two 4x4 fetchers (base 0 and base 250) driven in lockstep by one
// modelled master; expected windows and read addresses come from an image-level model.
module tb_sobel_window_fetch;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int NI = 2;

    logic       HCLK = 1'b0;
    logic       HRESET = 1'b1;
    logic       frame_start = 1'b0;
    logic       busy = 1'b0;
    logic       win_ready = 1'b1;
    logic [7:0] data_r_tb [NI];
    logic [7:0] mem [256];

    int checks = 0;
    int errors = 0;
    int frames = 0;
    int lat = 1;
    bit lat_rand = 1'b0;
    bit rdy_rand = 1'b0;
    bit stall_en = 1'b0;
    int stall_cnt = 0;
    int done_cnt [NI];
    int rd_cnt [NI];
    int win_cnt [NI];

    logic [7:0]  exp_addr [NI][$];
    logic [71:0] exp_win  [NI][$];
    logic [15:0] exp_xy   [NI][$];

    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input int inst, input logic [71:0] act,
                       input logic [71:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s inst%0d actual=%0h required=%0h", name, inst, act, req);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : u
        sobel_window_fetch_if bus ();
        logic fa;
        logic fd;

        assign bus.busy      = busy;
        assign bus.win_ready = win_ready;
        assign bus.data_r    = data_r_tb[g];

        sobel_window_fetch #(
            .IMG_W     (W),
            .IMG_H     (H),
            .BASE_ADDR (g == 0 ? 0 : 250)
        ) dut (
            .HCLK         (HCLK),
            .HRESET       (HRESET),
            .frame_start  (frame_start),
            .frame_active (fa),
            .frame_done   (fd),
            .bus          (bus.master)
        );

        initial begin : mon
            logic        rst_prev;
            logic        prev_issue, prev_valid, prev_acc, prev_start, prev_fd;
            logic [71:0] prev_data;
            logic [15:0] prev_xy;
            rst_prev = 1'b1;
            prev_issue = 0; prev_valid = 0; prev_acc = 0; prev_start = 0; prev_fd = 0;
            prev_data = '0; prev_xy = '0;
            forever begin
                @(negedge HCLK);
                if (rst_prev) begin
                    chk("rst_instruction", g, 72'(bus.instruction), 72'(0));
                    chk("rst_addr_r", g, 72'(bus.addr_r), 72'(0));
                    chk("rst_addr_w", g, 72'(bus.addr_w), 72'(0));
                    chk("rst_data_w", g, 72'(bus.data_w), 72'(0));
                    chk("rst_win_valid", g, 72'(bus.win_valid), 72'(0));
                    chk("rst_win_data", g, bus.win_data, 72'(0));
                    chk("rst_win_xy", g, 72'({bus.win_x, bus.win_y}), 72'(0));
                    chk("rst_frame_active", g, 72'(fa), 72'(0));
                    chk("rst_frame_done", g, 72'(fd), 72'(0));
                    rd_cnt[g] = 0;
                    win_cnt[g] = 0;
                    prev_issue = 0; prev_valid = 0; prev_acc = 0; prev_start = 0; prev_fd = 0;
                end else if (!HRESET) begin
                    chk("instr_not_write", g, 72'(bus.instruction == 2'b10), 72'(0));
                    if (bus.instruction == 2'b01) begin
                        chk("issue_busy_low", g, 72'(busy), 72'(0));
                        chk("issue_one_cycle", g, 72'(prev_issue), 72'(0));
                        chk("no_prefetch", g, 72'(bus.win_valid), 72'(0));
                        chk("issue_in_frame", g, 72'(fa), 72'(1));
                        if (exp_addr[g].size() == 0) begin
                            checks++; errors++;
                            $display("FAIL addr_r inst%0d actual=%0d required=no read", g, bus.addr_r);
                        end else begin
                            chk("addr_r", g, 72'(bus.addr_r), 72'(exp_addr[g].pop_front()));
                        end
                        rd_cnt[g]++;
                    end
                    if (prev_start) begin
                        chk("active_rise", g, 72'(fa), 72'(1));
                        if (!busy) chk("start_to_issue", g, 72'(bus.instruction), 72'(1));
                    end
                    if (prev_acc && !fd && !busy)
                        chk("accept_to_issue", g, 72'(bus.instruction), 72'(1));
                    if (bus.win_valid) begin
                        if (prev_valid && !prev_acc) begin
                            chk("win_stable_data", g, bus.win_data, prev_data);
                            chk("win_stable_xy", g, 72'({bus.win_x, bus.win_y}), 72'(prev_xy));
                        end
                        if (win_ready) begin
                            if (exp_win[g].size() == 0) begin
                                checks++; errors++;
                                $display("FAIL win_data inst%0d actual=(%0d,%0d) required=no window",
                                         g, bus.win_x, bus.win_y);
                            end else begin
                                chk("win_data", g, bus.win_data, exp_win[g].pop_front());
                                chk("win_xy", g, 72'({bus.win_x, bus.win_y}),
                                    72'(exp_xy[g].pop_front()));
                            end
                            win_cnt[g]++;
                        end
                    end
                    if (prev_fd) chk("done_one_cycle", g, 72'(fd), 72'(0));
                    if (fd) begin
                        chk("done_windows", g, 72'(win_cnt[g]), 72'((W - 2) * (H - 2)));
                        chk("done_reads", g, 72'(rd_cnt[g]),
                            72'(9 * (H - 2) + 3 * (W - 3) * (H - 2)));
                        chk("done_active_low", g, 72'(fa), 72'(0));
                        done_cnt[g]++;
                        rd_cnt[g] = 0;
                        win_cnt[g] = 0;
                    end
                    prev_issue = (bus.instruction == 2'b01);
                    prev_valid = bus.win_valid;
                    prev_acc   = bus.win_valid && win_ready;
                    prev_data  = bus.win_data;
                    prev_xy    = {bus.win_x, bus.win_y};
                    prev_start = frame_start && !fa && !fd;
                    prev_fd    = fd;
                end
                rst_prev = HRESET;
            end
        end
    end

    // Master model: busy rises the cycle after issue, data returns as busy falls.
    initial begin
        logic [7:0] a0, a1;
        int n;
        data_r_tb[0] = '0;
        data_r_tb[1] = '0;
        forever begin
            @(negedge HCLK);
            if (u[0].bus.instruction == 2'b01) begin
                a0 = u[0].bus.addr_r;
                a1 = u[1].bus.addr_r;
                n  = lat_rand ? int'($urandom_range(1, 4)) : lat;
                @(posedge HCLK); #1 busy = 1'b1;
                repeat (n - 1) @(posedge HCLK);
                @(posedge HCLK); #1 busy = 1'b0;
                data_r_tb[0] = mem[a0];
                data_r_tb[1] = mem[a1];
            end
        end
    end

    initial begin
        forever begin
            @(posedge HCLK); #1;
            if (stall_en && u[0].bus.win_valid && u[0].bus.win_x == 8'd2 &&
                u[0].bus.win_y == 8'd1 && stall_cnt < 10) begin
                win_ready = 1'b0;
                stall_cnt++;
            end else begin
                win_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    function automatic logic [7:0] pix_addr(input int base, input int x, input int y);
        return 8'((base + y * W + x) % 256);
    endfunction

    task automatic push_frame();
        for (int g = 0; g < NI; g++) begin
            int base;
            base = (g == 0) ? 0 : 250;
            for (int cy = 1; cy <= H - 2; cy++) begin
                for (int cx = 1; cx <= W - 2; cx++) begin
                    logic [71:0] w;
                    w = '0;
                    for (int r = 0; r < 3; r++)
                        for (int c = 0; c < 3; c++)
                            w[8 * (3 * r + c) +: 8] = mem[pix_addr(base, cx - 1 + c, cy - 1 + r)];
                    exp_win[g].push_back(w);
                    exp_xy[g].push_back({8'(cx), 8'(cy)});
                    for (int c = (cx == 1) ? 0 : 2; c < 3; c++)
                        for (int r = 0; r < 3; r++)
                            exp_addr[g].push_back(pix_addr(base, cx - 1 + c, cy - 1 + r));
                end
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge HCLK); #1 frame_start = 1'b1;
        @(posedge HCLK); #1 frame_start = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        frames++;
        i = 0;
        while (i < 5000 && done_cnt[0] < frames) begin
            @(posedge HCLK);
            i++;
        end
        checks++;
        if (done_cnt[0] < frames) begin
            errors++;
            $display("FAIL frame_timeout actual=%0d required=%0d", done_cnt[0], frames);
        end
        chk("done_lockstep", 1, 72'(done_cnt[1]), 72'(frames));
        repeat (3) @(posedge HCLK);
    endtask

    task automatic run_frame();
        push_frame();
        pulse_start();
        wait_done();
    endtask

    initial begin
        int i;
        done_cnt = '{default: 0};
        rd_cnt   = '{default: 0};
        win_cnt  = '{default: 0};
        for (int a = 0; a < 256; a++) mem[a] = 8'(a);
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;
        repeat (2) @(posedge HCLK);

        run_frame();

        stall_en = 1'b1;
        stall_cnt = 0;
        run_frame();
        stall_en = 1'b0;
        chk("stall_cycles", 0, 72'(stall_cnt), 72'(10));

        lat = 5;
        run_frame();
        lat = 1;

        push_frame();
        pulse_start();
        i = 0;
        while (i < 2000 && !(u[0].bus.win_valid && u[0].bus.win_x == 8'd1 && u[0].bus.win_y == 8'd2)) begin
            @(negedge HCLK);
            i++;
        end
        checks++;
        if (i >= 2000) begin
            errors++;
            $display("FAIL reach_window_1_2 actual=timeout required=window (1,2)");
        end
        pulse_start();
        wait_done();

        push_frame();
        pulse_start();
        i = 0;
        while (i < 2000 && rd_cnt[0] < 12) begin
            @(posedge HCLK);
            i++;
        end
        checks++;
        if (rd_cnt[0] < 12) begin
            errors++;
            $display("FAIL reach_read_12 actual=%0d required=12", rd_cnt[0]);
        end
        #1 HRESET = 1'b1;
        for (int g = 0; g < NI; g++) begin
            exp_addr[g].delete();
            exp_win[g].delete();
            exp_xy[g].delete();
        end
        @(posedge HCLK); #1 HRESET = 1'b0;
        repeat (8) @(posedge HCLK);
        chk("no_window_after_reset", 0, 72'(u[0].bus.win_valid), 72'(0));
        run_frame();

        rdy_rand = 1'b1;
        lat_rand = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
            run_frame();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
